prog_sequencer: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the 9-bit processor datapath and drives its DIN and run inputs.
- Reads a program from an external synchronous-read ROM, issues one instruction at a time and handshakes on the datapath's IRin/Done.
- Supplies the immediate word for mvi instructions, then advances the PC.
- Stops after executing the word at LAST_ADDR.

---
 rtl/prog_sequencer.sv | 163 ++++++++++++++++
 tb/tb_prog_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer: instruction-fetch stage in front of the 9-bit datapath.
// Reads a program from a synchronous-read ROM, issues one instruction at a
// time on DIN/run, supplies the immediate word of mvi, and halts after the
// word at LAST_ADDR completes.
// Optional build macro: SEQ_WATCHDOG_EN adds a Done timeout that halts the
// sequencer with err=1 after WDOG_CYCLES cycles in a wait state.
//
// Handshake: run is a one-cycle request (ISSUE only) asking the datapath to
// load DIN as an instruction; IRin marks the cycle the datapath loads it, and
// Done marks completion. Done seen in WAIT_IR (with or before IRin) also counts
// as completion. IRin/Done outside WAIT_IR/WAIT_DONE are ignored.
module prog_sequencer #(
  parameter int         ADDR_W      = 5,
  parameter int         LAST_ADDR   = 31,
  parameter logic [2:0] MVI_OPCODE  = 3'b001,
  parameter int         WDOG_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [8:0]        mem_rdata,
  output logic [8:0]        DIN,
  output logic              run,
  input  logic              IRin,
  input  logic              Done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [2:0]        seq_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH0    = 3'd1,
    S_FETCH1    = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_IR   = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  state_t            state;
  state_t            state_next;
  logic [8:0]        cur_word;
  logic [8:0]        nxt_word;
  logic              is_mvi;
  logic              in_wait;
  logic              complete;
  logic              covers_last;
  logic              wd_trip;
  logic              accept_start;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_next;

  assign is_mvi       = (cur_word[8:6] == MVI_OPCODE);
  assign in_wait      = (state == S_WAIT_IR) || (state == S_WAIT_DONE);
  assign complete     = in_wait && Done;
  assign accept_start = ((state == S_IDLE) || (state == S_HALT)) && start;
  // Address arithmetic wraps naturally at ADDR_W bits.
  assign pc_plus1     = pc + ADDR_W'(1);
  assign pc_next      = is_mvi ? (pc + ADDR_W'(2)) : pc_plus1;
  // An mvi whose immediate sits at LAST_ADDR also ends the program.
  assign covers_last  = (pc == LAST) || (is_mvi && (pc_plus1 == LAST));
  assign seq_state    = state;

`ifdef SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;
  logic [WD_W-1:0] wd_cnt;

  assign wd_trip = in_wait && !Done && (wd_cnt == WD_W'(WDOG_CYCLES - 1));

  // Wait-cycle counter restarted at each issue, plus the sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state == S_ISSUE) wd_cnt <= '0;
      else if (in_wait)     wd_cnt <= wd_cnt + WD_W'(1);
      if (accept_start)     err <= 1'b0;
      else if (wd_trip)     err <= 1'b1;
    end
  end
`else
  assign wd_trip = 1'b0;
  assign err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic and the DIN/run outputs decoded from state.
  always_comb begin
    state_next = state;
    run        = 1'b0;
    DIN        = 9'd0;
    case (state)
      S_IDLE, S_HALT: if (start) state_next = S_FETCH0;
      S_FETCH0:       state_next = S_FETCH1;
      S_FETCH1:       state_next = S_ISSUE;
      S_ISSUE: begin
        run        = 1'b1;
        DIN        = cur_word;
        state_next = S_WAIT_IR;
      end
      S_WAIT_IR: begin
        DIN = cur_word;
        if (IRin) state_next = S_WAIT_DONE;
      end
      S_WAIT_DONE:    DIN = is_mvi ? nxt_word : cur_word;
      default:        state_next = S_IDLE;
    endcase
    if (complete)     state_next = covers_last ? S_HALT : S_FETCH0;
    else if (wd_trip) state_next = S_HALT;
  end

  // PC, ROM address, fetched words and status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= '0;
      mem_addr <= '0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      cur_word <= 9'd0;
      nxt_word <= 9'd0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc       <= '0;
            mem_addr <= '0;
            busy     <= 1'b1;
            halted   <= 1'b0;
          end
        end
        S_FETCH0: mem_addr <= pc_plus1;
        S_FETCH1: cur_word <= mem_rdata;
        S_ISSUE:  nxt_word <= mem_rdata;
        default:  ;
      endcase
      if (complete) begin
        if (covers_last) begin
          busy   <= 1'b0;
          halted <= 1'b1;
        end else begin
          pc       <= pc_next;
          mem_addr <= pc_next;
        end
      end else if (wd_trip) begin
        busy   <= 1'b0;
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: randomized self-checking bench for prog_sequencer.
// The reference model walks the ROM image to list every instruction the
// sequencer must issue (pc, word, immediate) and the bench checks each issue.
module tb_prog_sequencer;

  localparam int         ADDR_W      = 5;
  localparam int         LAST_ADDR   = 31;
  localparam logic [2:0] MVI_OPCODE  = 3'b001;
  localparam int         WDOG_CYCLES = 64;
  localparam int         DEPTH       = 1 << ADDR_W;
  localparam int         EW          = 1 + ADDR_W + 18;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        mem_rdata;
  logic [8:0]        DIN;
  logic              run;
  logic              IRin;
  logic              Done;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              halted;
  logic              err;
  logic [2:0]        seq_state;

  logic [8:0]    rom [DEPTH];
  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  bit            noise_en = 1'b0;

  prog_sequencer #(
    .ADDR_W(ADDR_W), .LAST_ADDR(LAST_ADDR),
    .MVI_OPCODE(MVI_OPCODE), .WDOG_CYCLES(WDOG_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .DIN(DIN), .run(run), .IRin(IRin), .Done(Done),
    .pc(pc), .busy(busy), .halted(halted), .err(err), .seq_state(seq_state)
  );

  // Clock and synchronous-read ROM.
  always #5 clk = ~clk;
  always @(posedge clk) mem_rdata <= rom[mem_addr];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "time limit reached");
  end

  // ---------------- reference model ----------------
  task automatic fill_rom(input int mvi_pct);
    logic [8:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 99) < mvi_pct) w[8:6] = MVI_OPCODE;
      else if (w[8:6] == MVI_OPCODE)       w[8:6] = 3'b010;
      rom[i] = w;
    end
  endtask

  task automatic build_expected();
    int a;
    int nxt;
    logic [8:0] w;
    logic m;
    logic [ADDR_W-1:0] pa;
    exp_q.delete();
    a = 0;
    for (int n = 0; n < DEPTH; n++) begin
      w   = rom[a];
      m   = (w[8:6] == MVI_OPCODE);
      nxt = (a + 1) % DEPTH;
      pa  = a[ADDR_W-1:0];
      exp_q.push_back({m, pa, w, rom[nxt]});
      if (a == LAST_ADDR || (m && nxt == LAST_ADDR)) break;
      a = (a + (m ? 2 : 1)) % DEPTH;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic execute_instr(input logic [EW-1:0] e, input bit is_last);
    logic m;
    logic [ADDR_W-1:0] e_pc, e_after;
    logic [8:0] e_word, e_imm, e_hold;
    int lat, mode, d1, d2;
    {m, e_pc, e_word, e_imm} = e;
    e_hold  = m ? e_imm : e_word;
    e_after = e_pc + (m ? ADDR_W'(2) : ADDR_W'(1));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      IRin = 1'b0; Done = 1'b0; start = 1'b0;
      if (run !== 1'b1 && noise_en) begin
        IRin  = 1'($urandom_range(0, 1));
        Done  = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
      end
    end while (run !== 1'b1 && lat < 10);
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL run_timeout: no run for pc %0d after %0d cycles", e_pc, lat);
      return;
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL run_latency: got %0d cycles, expected 2", lat);
    end
    checks++;
    if (pc !== e_pc || DIN !== e_word) begin
      errors++;
      $display("FAIL issue: pc=%0d DIN=%h, expected pc=%0d DIN=%h", pc, DIN, e_pc, e_word);
    end
    mode = $urandom_range(0, 2);
    d1   = $urandom_range(0, 2);
    d2   = $urandom_range(1, 4);
    @(negedge clk);
    checks++;
    if (run !== 1'b0 || DIN !== e_word) begin
      errors++;
      $display("FAIL run_single: run=%b DIN=%h, expected run=0 DIN=%h", run, DIN, e_word);
    end
    for (int i = 0; i < d1; i++) begin
      @(negedge clk);
      checks++;
      if (run !== 1'b0 || DIN !== e_word) begin
        errors++;
        $display("FAIL wait_ir_hold: run=%b DIN=%h, expected run=0 DIN=%h", run, DIN, e_word);
      end
    end
    case (mode)
      0: begin
        IRin = 1'b1; start = noise_en;
        @(negedge clk);
        IRin = 1'b0; start = 1'b0;
        for (int i = 0; i < d2; i++) begin
          if (i > 0) @(negedge clk);
          checks++;
          if (DIN !== e_hold || run !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_done_hold: DIN=%h run=%b busy=%b, expected DIN=%h run=0 busy=1",
                     DIN, run, busy, e_hold);
          end
        end
        Done = 1'b1;
      end
      1: begin IRin = 1'b1; Done = 1'b1; end
      default: Done = 1'b1;
    endcase
    @(negedge clk);
    IRin = 1'b0; Done = 1'b0;
    checks++;
    if (is_last) begin
      if (halted !== 1'b1 || busy !== 1'b0 || pc !== e_pc) begin
        errors++;
        $display("FAIL halt_state: halted=%b busy=%b pc=%0d, expected 1 0 %0d", halted, busy, pc, e_pc);
      end
    end else if (halted !== 1'b0 || busy !== 1'b1 || pc !== e_after || mem_addr !== e_after) begin
      errors++;
      $display("FAIL advance: halted=%b busy=%b pc=%0d mem_addr=%0d, expected 0 1 %0d %0d",
               halted, busy, pc, mem_addr, e_after, e_after);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic run_program();
    logic [EW-1:0] e;
    logic [ADDR_W-1:0] final_pc;
    build_expected();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || halted !== 1'b0 || err !== 1'b0 || pc !== '0 || run !== 1'b0) begin
      errors++;
      $display("FAIL start_accept: busy=%b halted=%b err=%b pc=%0d run=%b, expected 1 0 0 0 0",
               busy, halted, err, pc, run);
    end
    final_pc = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      final_pc = e[EW-2 -: ADDR_W];
      execute_instr(e, exp_q.size() == 0);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      Done = (i == 1);
      IRin = (i == 2);
      checks++;
      if (run !== 1'b0 || halted !== 1'b1 || busy !== 1'b0 || pc !== final_pc) begin
        errors++;
        $display("FAIL post_halt: run=%b halted=%b busy=%b pc=%0d, expected 0 1 0 %0d",
                 run, halted, busy, pc, final_pc);
      end
    end
    Done = 1'b0; IRin = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_addr !== '0 || pc !== '0 || DIN !== 9'd0 || run !== 1'b0 ||
        busy !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: mem_addr=%0d pc=%0d DIN=%h run=%b busy=%b halted=%b err=%b, expected all 0",
               mem_addr, pc, DIN, run, busy, halted, err);
    end
    rst = 1'b1;
    @(negedge clk); Done = 1'b1; IRin = 1'b1;
    @(negedge clk); Done = 1'b0; IRin = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (run !== 1'b0 || busy !== 1'b0 || pc !== '0 || halted !== 1'b0) begin
        errors++;
        $display("FAIL idle_ignore: run=%b busy=%b pc=%0d halted=%b, expected 0 0 0 0", run, busy, pc, halted);
      end
    end
  endtask

  task automatic test_mvi_basic();
    fill_rom(0);
    rom[0] = 9'h040;
    rom[1] = 9'h05A;
    rom[2] = 9'h1C0;
    run_program();
  endtask

  task automatic test_random_programs();
    for (int k = 0; k < 4; k++) begin
      fill_rom(25);
      run_program();
    end
  endtask

  task automatic test_mvi_covers_last();
    fill_rom(0);
    rom[30] = {MVI_OPCODE, 6'h15};
    run_program();
  endtask

  task automatic test_mvi_wrap();
    fill_rom(0);
    rom[31] = {MVI_OPCODE, 6'h2A};
    run_program();
  endtask

  task automatic test_back_to_back();
    noise_en = 1'b1;
    fill_rom(30);
    run_program();
    fill_rom(30);
    run_program();
    noise_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    fill_rom(20);
    rom[0] = 9'h008;
    build_expected();
    pulse_start();
    execute_instr(exp_q.pop_front(), 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_issue: run=%b, expected 1", run);
    end
    @(negedge clk); IRin = 1'b1;
    @(negedge clk); IRin = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_addr !== '0 || pc !== '0 || DIN !== 9'd0 || run !== 1'b0 ||
        busy !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: mem_addr=%0d pc=%0d DIN=%h run=%b busy=%b halted=%b err=%b, expected all 0",
               mem_addr, pc, DIN, run, busy, halted, err);
    end
    @(negedge clk); rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (run !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_run: run=%b busy=%b, expected 0 0", run, busy);
      end
    end
    run_program();
  endtask

  task automatic test_watchdog();
    int n;
    fill_rom(0);
    rom[0] = 9'h008;
    pulse_start();
    repeat (2) @(negedge clk);
    checks++;
    if (run !== 1'b1) begin
      errors++;
      $display("FAIL wd_issue: run=%b, expected 1", run);
    end
    @(negedge clk); IRin = 1'b1;
    @(negedge clk); IRin = 1'b0;
    n = 2;
    while (halted !== 1'b1 && n < 150) begin
      @(negedge clk);
      n++;
    end
`ifdef SEQ_WATCHDOG_EN
    checks++;
    if (n - 1 != WDOG_CYCLES) begin
      errors++;
      $display("FAIL wd_latency: halted after %0d cycles, expected %0d", n - 1, WDOG_CYCLES);
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || DIN !== 9'd0) begin
      errors++;
      $display("FAIL wd_flags: err=%b busy=%b DIN=%h, expected 1 0 000", err, busy, DIN);
    end
`else
    checks++;
    if (halted !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL no_wd_wait: halted=%b busy=%b err=%b, expected 0 1 0", halted, busy, err);
    end
    Done = 1'b1;
    @(negedge clk); Done = 1'b0;
    checks++;
    if (busy !== 1'b1 || pc !== ADDR_W'(1)) begin
      errors++;
      $display("FAIL no_wd_resume: busy=%b pc=%0d, expected 1 1", busy, pc);
    end
`endif
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst = 1'b0; start = 1'b0; IRin = 1'b0; Done = 1'b0;
    fill_rom(0);
    test_reset();
    test_mvi_basic();
    test_random_programs();
    test_mvi_covers_last();
    test_mvi_wrap();
    test_back_to_back();
    test_reset_mid();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
